// File: rtl/axi4_rd_arb_pkg.sv
// Shared types and constants for the AXI4 read arbiter: AR FSM states,
// AXI burst/response encodings and the registered AR control payload.
package axi4_rd_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } ar_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int OUT_CNT_W = 8;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ar_ctrl_t;

endpackage

// File: rtl/axi4_rr_arb.sv
// Round-robin arbiter: searches upward from the pointer with wrap and moves
// the pointer just past the winner whenever the grant is consumed.
module axi4_rr_arb
    import axi4_rd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (advance)
            ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/axi4_read_arbiter.sv
// N-to-1 AXI4 read arbiter with outstanding-burst limit and ID-based R routing.
// Define AXI4_RD_ARB_ERR_CHECK_EN to sink and flag R beats that match no burst.
//
//   state    | meaning
//   ST_IDLE  | waiting for a request; captures the round-robin winner
//   ST_ISSUE | holding the captured AR on the downstream port until m_arready
module axi4_read_arbiter
    import axi4_rd_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                ACLK,
    input  logic                                ARESETn,
    input  logic [NUM_REQ-1:0]                  s_arvalid,
    output logic [NUM_REQ-1:0]                  s_arready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       s_araddr,
    input  logic [NUM_REQ*ID_WIDTH-1:0]         s_arid,
    input  logic [NUM_REQ*8-1:0]                s_arlen,
    input  logic [NUM_REQ*3-1:0]                s_arsize,
    input  logic [NUM_REQ*2-1:0]                s_arburst,
    output logic [NUM_REQ-1:0]                  s_rvalid,
    input  logic [NUM_REQ-1:0]                  s_rready,
    output logic [DATA_WIDTH-1:0]               s_rdata,
    output logic [ID_WIDTH-1:0]                 s_rid,
    output logic [1:0]                          s_rresp,
    output logic                                s_rlast,
    output logic                                m_arvalid,
    input  logic                                m_arready,
    output logic [ADDR_WIDTH-1:0]               m_araddr,
    output logic [ID_WIDTH+$clog2(NUM_REQ)-1:0] m_arid,
    output logic [7:0]                          m_arlen,
    output logic [2:0]                          m_arsize,
    output logic [1:0]                          m_arburst,
    input  logic                                m_rvalid,
    output logic                                m_rready,
    input  logic [DATA_WIDTH-1:0]               m_rdata,
    input  logic [ID_WIDTH+$clog2(NUM_REQ)-1:0] m_rid,
    input  logic [1:0]                          m_rresp,
    input  logic                                m_rlast,
    output logic                                err_unexpected
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int MID_W = ID_WIDTH + IDX_W;

    ar_state_t              state, state_nx;
    logic [1:0]             rst_sync;
    logic                   run;
    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   capture;
    logic                   r_last_hs;
    logic [OUT_CNT_W-1:0]   outstanding;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [MID_W-1:0]       id_q;
    ar_ctrl_t               ctrl_q;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_idx_ok;

    // Captures are held off until the release of reset has crossed two flops.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    assign capture = (state == ST_IDLE) && run && (|s_arvalid)
                     && (outstanding < OUT_CNT_W'(MAX_OUTSTANDING));

    axi4_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .req       (s_arvalid),
        .advance   (capture),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (capture)   state_nx = ST_ISSUE;
            ST_ISSUE: if (m_arready) state_nx = ST_IDLE;
            default:                 state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        s_arready = '0;
        m_arvalid = (state == ST_ISSUE);
        if (capture) s_arready = grant;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q <= '0;
            id_q   <= '0;
            ctrl_q <= '0;
        end else if (capture) begin
            addr_q       <= s_araddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            id_q         <= {grant_idx, s_arid[grant_idx*ID_WIDTH +: ID_WIDTH]};
            ctrl_q.len   <= s_arlen[grant_idx*8 +: 8];
            ctrl_q.size  <= s_arsize[grant_idx*3 +: 3];
            ctrl_q.burst <= s_arburst[grant_idx*2 +: 2];
        end
    end

    assign m_araddr  = addr_q;
    assign m_arid    = id_q;
    assign m_arlen   = ctrl_q.len;
    assign m_arsize  = ctrl_q.size;
    assign m_arburst = ctrl_q.burst;

    assign r_last_hs = m_rvalid && m_rready && m_rlast;

    // Capture and last beat on the same edge cancel; the count floors at zero.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            outstanding <= '0;
        else if (capture && !r_last_hs)
            outstanding <= outstanding + 1'b1;
        else if (!capture && r_last_hs && outstanding != '0)
            outstanding <= outstanding - 1'b1;
    end

    assign r_idx    = m_rid[MID_W-1:ID_WIDTH];
    assign r_idx_ok = {1'b0, r_idx} < (IDX_W+1)'(NUM_REQ);
    assign s_rdata  = m_rdata;
    assign s_rid    = m_rid[ID_WIDTH-1:0];
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;

`ifdef AXI4_RD_ARB_ERR_CHECK_EN
    logic sink;
    assign sink = m_rvalid && (!r_idx_ok || outstanding == '0);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)  err_unexpected <= 1'b0;
        else if (sink) err_unexpected <= 1'b1;
    end
`else
    assign err_unexpected = 1'b0;
`endif

    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (r_idx == IDX_W'(i)) s_rvalid[i] = m_rvalid;
        if (r_idx_ok) m_rready = s_rready[r_idx];
`ifdef AXI4_RD_ARB_ERR_CHECK_EN
        if (sink) begin
            s_rvalid = '0;
            m_rready = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Scoreboard bench for axi4_read_arbiter: expected AR/R transfers are queued
// as stimulus is driven and compared when the DUT hands them over.
module tb_axi4_read_arbiter;
    import axi4_rd_arb_pkg::*;

    localparam int N = 4, AW = 32, DW = 32, IW = 4, MAXO = 5, XW = 2, MW = 6;

    logic ACLK = 1'b0, ARESETn;
    logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*AW-1:0] s_araddr;
    logic [N*IW-1:0] s_arid;
    logic [N*8-1:0]  s_arlen;
    logic [N*3-1:0]  s_arsize;
    logic [N*2-1:0]  s_arburst;
    logic [DW-1:0]   s_rdata, m_rdata;
    logic [IW-1:0]   s_rid;
    logic [1:0]      s_rresp, m_rresp, m_arburst;
    logic            s_rlast, m_rlast, m_arvalid, m_arready, m_rvalid, m_rready, err_unexpected;
    logic [AW-1:0]   m_araddr;
    logic [MW-1:0]   m_arid, m_rid;
    logic [7:0]      m_arlen;
    logic [2:0]      m_arsize;

    axi4_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
                        .MAX_OUTSTANDING(MAXO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .err_unexpected(err_unexpected)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [AW-1:0] addr; logic [MW-1:0] id; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
    } ar_exp_t;
    typedef struct {
        logic [N-1:0] dst; logic [DW-1:0] data; logic [IW-1:0] id; logic [1:0] resp; logic last;
    } r_exp_t;

    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    int      cap_idx_q[$], cap_cyc_q[$];
    int      n_cmp = 0, n_bad = 0, cyc = 0, t_grant;
    ar_exp_t ea;
    r_exp_t  er;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(negedge ACLK) if (ARESETn) begin
        if (m_arvalid && m_arready) begin
            if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
            else begin
                ea = ar_q.pop_front();
                check("m_araddr", m_araddr, ea.addr);
                check("m_arid", m_arid, ea.id);
                check("m_arlen", m_arlen, ea.len);
                check("m_arsize", m_arsize, ea.size);
                check("m_arburst", m_arburst, ea.burst);
            end
        end
        if (|s_arready) begin
            check("arready_onehot", $countones(s_arready), 1);
            check("arready_in_arvalid", s_arready & ~s_arvalid, 0);
            for (int i = 0; i < N; i++)
                if (s_arready[i]) begin cap_idx_q.push_back(i); cap_cyc_q.push_back(cyc); end
        end
        if (|(s_rvalid & s_rready)) begin
            if (r_q.size() == 0) check("r_unexpected", 1, 0);
            else begin
                er = r_q.pop_front();
                check("r_dst", s_rvalid, er.dst);
                check("r_data", s_rdata, er.data);
                check("r_id", s_rid, er.id);
                check("r_resp", s_rresp, er.resp);
                check("r_last", s_rlast, er.last);
                check("r_mready", m_rready, 1);
            end
        end
    end

    task automatic tick; @(posedge ACLK); #1; endtask

    task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        s_araddr[i*AW +: AW] = addr;
        s_arid[i*IW +: IW]   = id;
        s_arlen[i*8 +: 8]    = len;
        s_arsize[i*3 +: 3]   = size;
        s_arburst[i*2 +: 2]  = burst;
    endtask

    task automatic expect_ar(input int i);
        ar_exp_t e;
        e.addr  = s_araddr[i*AW +: AW];
        e.id    = {XW'(i), s_arid[i*IW +: IW]};
        e.len   = s_arlen[i*8 +: 8];
        e.size  = s_arsize[i*3 +: 3];
        e.burst = s_arburst[i*2 +: 2];
        ar_q.push_back(e);
    endtask

    task automatic r_drive(input logic [MW-1:0] rid, input logic [DW-1:0] data,
                           input logic [1:0] resp, input logic last);
        m_rvalid = 1'b1; m_rid = rid; m_rdata = data; m_rresp = resp; m_rlast = last;
    endtask

    task automatic expect_r(input logic [N-1:0] dst, input logic [DW-1:0] data,
                            input logic [IW-1:0] id, input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.dst = dst; e.data = data; e.id = id; e.resp = resp; e.last = last;
        r_q.push_back(e);
    endtask

    task automatic wait_grant(input string tag, output int at_cyc);
        at_cyc = -1;
        for (int k = 0; k < 20 && at_cyc < 0; k++) begin
            @(negedge ACLK);
            if (s_arready != '0) at_cyc = cyc;
        end
        if (at_cyc < 0) check({tag, "_timeout"}, 1, 0);
    endtask

    task automatic do_reset;
        ARESETn = 1'b0; s_arvalid = '0; m_rvalid = 1'b0; s_rready = '0;
        ar_q.delete(); r_q.delete();
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        repeat (3) tick();
        cap_idx_q.delete(); cap_cyc_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order[5] = '{0, 1, 2, 3, 0};
        ARESETn = 1'b0; s_arvalid = '0; s_araddr = '0; s_arid = '0; s_arlen = '0;
        s_arsize = '0; s_arburst = '0; s_rready = '0; m_arready = 1'b0;
        m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;

        // reset state with a request already pending
        set_req(2, 32'h1000, 4'h3, 8'h03, 3'd2, BURST_INCR);
        s_arvalid = 4'b0100;
        repeat (2) @(negedge ACLK);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_arready", s_arready, 0);
        check("rst_err", err_unexpected, 0);
        check("rst_araddr", m_araddr, 0);
        check("rst_arid", m_arid, 0);

        // single request, release synchronisation, 1-cycle AR latency
        @(posedge ACLK); #1 ARESETn = 1'b1; m_arready = 1'b1;
        expect_ar(2);
        @(negedge ACLK); check("sync_edge0_arready", s_arready, 0);
        @(negedge ACLK); check("sync_edge1_arready", s_arready, 0);
        wait_grant("single", t_grant);
        check("single_grant", s_arready, 4'b0100);
        check("single_arvalid_capture_cycle", m_arvalid, 0);
        tick(); s_arvalid = '0;
        @(negedge ACLK); check("single_arvalid_next", m_arvalid, 1);
        @(negedge ACLK); check("single_arvalid_done", m_arvalid, 0);

        // all requesting: round-robin order, 2-cycle spacing, limit at MAXO
        do_reset();
        for (int i = 0; i < N; i++)
            set_req(i, 32'h2000 + i*32'h100, 4'h8 + IW'(i), 8'(i), 3'd2, (i == 2) ? BURST_WRAP : BURST_INCR);
        for (int k = 0; k < 5; k++) expect_ar(order[k]);
        s_arvalid = 4'b1111;
        repeat (16) tick();
        check("rr_capture_count", cap_idx_q.size(), 5);
        for (int k = 0; k < 5 && k < cap_idx_q.size(); k++) check("rr_order", cap_idx_q[k], order[k]);
        for (int k = 1; k < 5 && k < cap_idx_q.size(); k++) check("rr_spacing", cap_cyc_q[k] - cap_cyc_q[k-1], 2);
        @(negedge ACLK); check("full_blocks_arready", s_arready, 0);
        tick();
        r_drive({2'd1, 4'h9}, 32'hCAFE0001, RESP_OKAY, 1'b1); s_rready = 4'b0010;
        expect_r(4'b0010, 32'hCAFE0001, 4'h9, RESP_OKAY, 1'b1);
        expect_ar(1);
        @(negedge ACLK); check("full_arready_during_rlast", s_arready, 0);
        tick(); m_rvalid = 1'b0;
        @(negedge ACLK); check("freed_slot_grant", s_arready, 4'b0010);
        tick(); s_arvalid = '0;
        repeat (3) tick();

        // capture and last beat on the same edge leave the count unchanged
        do_reset();
        set_req(1, 32'h3100, 4'h1, 8'h00, 3'd1, BURST_FIXED);
        s_arvalid = 4'b0010; expect_ar(1);
        wait_grant("sim_first", t_grant);
        tick(); s_arvalid = '0;
        tick();
        set_req(3, 32'h3300, 4'h7, 8'h0F, 3'd2, BURST_INCR);
        s_arvalid = 4'b1000; expect_ar(3);
        r_drive({2'd0, 4'h8}, 32'h0BAD0BAD, RESP_OKAY, 1'b1); s_rready = 4'b0001;
        expect_r(4'b0001, 32'h0BAD0BAD, 4'h8, RESP_OKAY, 1'b1);
        @(negedge ACLK);
        check("sim_arready", s_arready, 4'b1000);
        check("sim_mready", m_rready, 1);
        tick(); m_rvalid = 1'b0; s_arvalid = '0; s_rready = '0;
        cap_idx_q.delete(); cap_cyc_q.delete();
        set_req(0, 32'h3000, 4'h2, 8'h01, 3'd2, BURST_INCR);
        set_req(2, 32'h3200, 4'h4, 8'h02, 3'd2, BURST_WRAP);
        for (int i = 0; i < N; i++) expect_ar(i);
        s_arvalid = 4'b1111;
        repeat (16) tick();
        check("sim_refill_count", cap_idx_q.size(), 4);
        s_arvalid = '0;
        repeat (2) tick();

        // R routing by ID, backpressure from the addressed requester only
        r_drive(6'h15, 32'h5A5A1234, RESP_SLVERR, 1'b0); s_rready = 4'b1101;
        @(negedge ACLK);
        check("route_rvalid", s_rvalid, 4'b0010);
        check("route_mready_stall", m_rready, 0);
        check("route_rid", s_rid, 4'h5);
        check("route_rdata", s_rdata, 32'h5A5A1234);
        tick(); s_rready = 4'b1111;
        expect_r(4'b0010, 32'h5A5A1234, 4'h5, RESP_SLVERR, 1'b0);
        @(negedge ACLK); check("route_mready_go", m_rready, 1);
        tick();
        r_drive(6'h3A, 32'h00C0FFEE, RESP_OKAY, 1'b0); s_rready = 4'b1000;
        expect_r(4'b1000, 32'h00C0FFEE, 4'hA, RESP_OKAY, 1'b0);
        @(negedge ACLK); check("route_rvalid_3", s_rvalid, 4'b1000);
        tick(); m_rvalid = 1'b0; s_rready = '0;

        // reset during ISSUE drops m_arvalid at once and discards the burst
        do_reset();
        m_arready = 1'b0;
        set_req(0, 32'h4000, 4'hE, 8'h00, 3'd2, BURST_INCR);
        s_arvalid = 4'b0001;
        wait_grant("mid_issue", t_grant);
        tick(); s_arvalid = '0;
        @(negedge ACLK); check("issue_holds", m_arvalid, 1);
        @(posedge ACLK); #2 ARESETn = 1'b0;
        #1 check("issue_reset_drop", m_arvalid, 0);
        do_reset();
        m_arready = 1'b1;
        @(negedge ACLK); check("issue_discarded", m_arvalid, 0);
        tick();

        // R beat with nothing outstanding
        r_drive({2'd2, 4'h1}, 32'h12345678, RESP_OKAY, 1'b1); s_rready = '0;
`ifdef AXI4_RD_ARB_ERR_CHECK_EN
        @(negedge ACLK);
        check("unexp_sink_mready", m_rready, 1);
        check("unexp_no_rvalid", s_rvalid, 0);
        tick(); m_rvalid = 1'b0;
        @(negedge ACLK); check("unexp_err_set", err_unexpected, 1);
        repeat (3) tick();
        @(negedge ACLK); check("unexp_err_sticky", err_unexpected, 1);
        ARESETn = 1'b0;
        #1 check("unexp_err_reset", err_unexpected, 0);
`else
        @(negedge ACLK);
        check("nochk_rvalid", s_rvalid, 4'b0100);
        check("nochk_mready", m_rready, 0);
        check("nochk_err", err_unexpected, 0);
        tick(); m_rvalid = 1'b0;
`endif

        check("ar_queue_drained", ar_q.size(), 0);
        check("r_queue_drained", r_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
